// File: rtl/risc16_control_fsm_pkg.sv
// ============================================================================
// Module   : risc16_control_fsm_pkg
// Purpose  : Shared definitions for the RISC_16 control unit. Holds the state
//            encodings, opcode constants, ALU function codes, the control-word
//            struct, and the per-state output decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package risc16_control_fsm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_LOAD_IR = 4'd2,
    ST_DECODE  = 4'd3,
    ST_EXEC    = 4'd4,
    ST_MEM     = 4'd5,
    ST_WB      = 4'd6,
    ST_BRANCH  = 4'd7,
    ST_JUMP    = 4'd8,
    ST_HALT    = 4'd9
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'h9;
  localparam logic [3:0] OP_BEQ   = 4'hA;
  localparam logic [3:0] OP_JMP   = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // One bit per strobe, plus the ALU function code.
  typedef struct packed {
    logic       pc_enable;
    logic       pc_increment;
    logic       pc_load;
    logic       ir_enable;
    logic       mem_enable;
    logic       mem_write;
    logic       addr_sel;
    logic       reg_enable;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

  // Opcodes 0x0-0x7 are register-to-register ALU operations.
  function automatic logic is_alu_op(input logic [3:0] op);
    return !op[3];
  endfunction

  // Opcodes that need the EXEC state: ALU ops, LOAD, STORE and BEQ.
  function automatic logic needs_exec(input logic [3:0] op);
    return is_alu_op(op) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BEQ);
  endfunction

  // Control word that the given state presents. The BRANCH state returns an
  // all-zero word here: its PC strobes depend on zero_flag, so the top level
  // gates them in separately.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      ST_FETCH: begin
        c.mem_enable = 1'b1;
      end
      ST_LOAD_IR: begin
        c.ir_enable    = 1'b1;
        c.pc_enable    = 1'b1;
        c.pc_increment = 1'b1;
      end
      ST_EXEC: begin
        if (is_alu_op(op)) begin
          c.alu_op = op[2:0];
        end else if (op == OP_BEQ) begin
          c.alu_op = ALU_SUB;
        end else begin
          c.alu_op = ALU_ADD;
        end
      end
      ST_MEM: begin
        c.mem_enable = 1'b1;
        c.addr_sel   = 1'b1;
        c.mem_write  = (op == OP_STORE);
      end
      ST_WB: begin
        c.reg_enable = 1'b1;
      end
      ST_JUMP: begin
        c.pc_enable = 1'b1;
        c.pc_load   = 1'b1;
      end
      ST_HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/risc16_wait_timer.sv
// ============================================================================
// Module   : risc16_wait_timer
// Purpose  : Counts consecutive cycles spent waiting for mem_ready. The
//            expired flag marks the MAX_WAIT-th waiting cycle, so the owner
//            can abort at the end of that cycle.
// Ports    : clk, rst   - clock and asynchronous active-high reset
//            i_clear    - synchronous clear of the count
//            i_enable   - this cycle is a waiting cycle
//            o_expired  - this waiting cycle is the last one allowed
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc16_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // The count holds the number of earlier waiting cycles, so the limit is
  // reached while the count shows MAX_WAIT-1.
  localparam logic [7:0] c_LIMIT = 8'(MAX_WAIT - 1);

  logic [7:0] r_count;

  assign o_expired = i_enable && (r_count == c_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/risc16_control_fsm.sv
// ============================================================================
// Module   : risc16_control_fsm
// Purpose  : Multi-cycle control unit for the RISC_16 datapath. Sequences
//            FETCH / LOAD_IR / DECODE / EXEC / MEM / WB / BRANCH / JUMP,
//            handles the mem_ready handshake with a bus-error timeout, halts
//            on HALT, and counts retired instructions.
// Ports    : clk, rst             - clock, asynchronous active-high reset
//            opcode, zero_flag    - from IR[15:12] and the ALU
//            mem_ready            - memory access completes this cycle
//            PC_enable..alu_op    - datapath control strobes
//            halted, bus_err      - core status
//            retired_count        - wrapping retired-instruction count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module risc16_control_fsm
  import risc16_control_fsm_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          opcode,
  input  logic                zero_flag,
  input  logic                mem_ready,
  output logic                PC_enable,
  output logic                pc_increment,
  output logic                pc_load,
  output logic                IR_enable,
  output logic                mem_enable,
  output logic                mem_write,
  output logic                addr_sel,
  output logic                reg_enable,
  output logic [2:0]          alu_op,
  output logic                halted,
  output logic                bus_err,
  output logic [RETIRE_W-1:0] retired_count
);

  state_t              r_state;
  ctrl_t               r_ctrl;
  logic                r_bus_err;
  logic [RETIRE_W-1:0] r_retired;

  state_t w_next;
  logic   w_retire;
  logic   w_timeout;
  logic   w_tmr_en;
  logic   w_tmr_clr;
  logic   w_expired;
  logic   w_branch_take;

  // Only FETCH and MEM wait on memory. Leaving either state requires
  // mem_ready or a timeout, so clearing whenever we are not waiting also
  // clears the timer on every state change.
  assign w_tmr_en  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
  assign w_tmr_clr = !w_tmr_en;

  risc16_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_tmr_clr),
    .i_enable  (w_tmr_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          w_next = ST_LOAD_IR;
        end else if (w_expired) begin
          w_next    = ST_HALT;
          w_timeout = 1'b1;
        end
      end
      ST_LOAD_IR: begin
        w_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (needs_exec(opcode)) begin
          w_next = ST_EXEC;
        end else if (opcode == OP_JMP) begin
          w_next = ST_JUMP;
        end else if (opcode == OP_HALT) begin
          w_next   = ST_HALT;
          w_retire = 1'b1;
        end else begin
          w_next   = ST_FETCH;
          w_retire = 1'b1;
        end
      end
      ST_EXEC: begin
        if (is_alu_op(opcode)) begin
          w_next = ST_WB;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          w_next = ST_MEM;
        end else begin
          w_next = ST_BRANCH;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            w_next   = ST_FETCH;
            w_retire = 1'b1;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_expired) begin
          w_next    = ST_HALT;
          w_timeout = 1'b1;
        end
      end
      ST_WB, ST_BRANCH, ST_JUMP: begin
        w_next   = ST_FETCH;
        w_retire = 1'b1;
      end
      ST_HALT: begin
        w_next = ST_HALT;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered as the decode of the state being entered, so they
  // line up exactly with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ctrl    <= '0;
      r_bus_err <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode_ctrl(w_next, opcode);
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
      if (w_retire) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  // zero_flag is captured by the datapath at the end of EXEC, so it is only
  // meaningful once BRANCH is the current state.
  assign w_branch_take = (r_state == ST_BRANCH) && zero_flag;

  assign PC_enable     = r_ctrl.pc_enable | w_branch_take;
  assign pc_increment  = r_ctrl.pc_increment;
  assign pc_load       = r_ctrl.pc_load | w_branch_take;
  assign IR_enable     = r_ctrl.ir_enable;
  assign mem_enable    = r_ctrl.mem_enable;
  assign mem_write     = r_ctrl.mem_write;
  assign addr_sel      = r_ctrl.addr_sel;
  assign reg_enable    = r_ctrl.reg_enable;
  assign alu_op        = r_ctrl.alu_op;
  assign halted        = r_ctrl.halted;
  assign bus_err       = r_bus_err;
  assign retired_count = r_retired;

endmodule

`default_nettype wire
